// File: rtl/dmi_pkg.sv
// Shared DMI definitions: field widths, op/status encodings, request/response
// word layouts and the endpoint FSM state type.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 6;
  localparam int unsigned DMI_DATA_W = 32;
  localparam int unsigned DMI_OP_W   = 2;

  localparam logic [DMI_OP_W-1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [DMI_OP_W-1:0] DMI_OP_READ  = 2'd1;
  localparam logic [DMI_OP_W-1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [DMI_OP_W-1:0] DMI_OP_RSVD  = 2'd3;

  localparam logic [DMI_OP_W-1:0] DMI_STATUS_OK     = 2'd0;
  localparam logic [DMI_OP_W-1:0] DMI_STATUS_FAILED = 2'd2;
  localparam logic [DMI_OP_W-1:0] DMI_STATUS_BUSY   = 2'd3;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_OP_W-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_OP_W-1:0]   op;
  } dmi_resp_t;

  // Encodings kept identical to the legacy localparam values.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DM_REQ  = 3'd1;
  localparam logic [2:0] ST_DM_WAIT = 3'd2;
  localparam logic [2:0] ST_RESP_HI = 3'd3;
  localparam logic [2:0] ST_RESP_LO = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_DM_REQ  = ST_DM_REQ,
    S_DM_WAIT = ST_DM_WAIT,
    S_RESP_HI = ST_RESP_HI,
    S_RESP_LO = ST_RESP_LO
  } dmi_state_e;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmi_dm_endpoint.sv
// DM-side DMI endpoint: 4-phase CDC handshake with the JTAG-domain DTM on one
// side, valid/ready request/response channels toward the debug module on the other.
module dmi_dm_endpoint
  import dmi_pkg::*;
#(
  parameter int unsigned DMI_ADDR_BITS = DMI_ADDR_W,
  parameter int unsigned DMI_DATA_BITS = DMI_DATA_W,
  parameter int unsigned DMI_OP_BITS   = DMI_OP_W,
  localparam int unsigned W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dtm_req_i,
  input  logic [W-1:0]             dtm_req_data_i,
  output logic                     dtm_ack_o,
  output logic                     dtm_resp_o,
  output logic [W-1:0]             dtm_resp_data_o,
  input  logic                     dtm_resp_ack_i,
  output logic                     dmi_req_valid_o,
  input  logic                     dmi_req_ready_i,
  output logic [DMI_ADDR_BITS-1:0] dmi_req_addr_o,
  output logic [DMI_DATA_BITS-1:0] dmi_req_data_o,
  output logic [DMI_OP_BITS-1:0]   dmi_req_op_o,
  input  logic                     dmi_resp_valid_i,
  output logic                     dmi_resp_ready_o,
  input  logic [DMI_DATA_BITS-1:0] dmi_resp_data_i,
  input  logic [DMI_OP_BITS-1:0]   dmi_resp_op_i
);

  localparam logic [DMI_OP_BITS-1:0] OP_NOP     = DMI_OP_BITS'(DMI_OP_NOP);
  localparam logic [DMI_OP_BITS-1:0] OP_READ    = DMI_OP_BITS'(DMI_OP_READ);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE   = DMI_OP_BITS'(DMI_OP_WRITE);
  localparam logic [DMI_OP_BITS-1:0] RSP_OK     = DMI_OP_BITS'(DMI_STATUS_OK);
  localparam logic [DMI_OP_BITS-1:0] RSP_FAILED = DMI_OP_BITS'(DMI_STATUS_FAILED);

  logic sync_req;
  logic sync_ack;

  cdc_sync_2ff u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dtm_req_i),
    .q     (sync_req)
  );

  cdc_sync_2ff u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dtm_resp_ack_i),
    .q     (sync_ack)
  );

  dmi_state_e               state_q;
  logic [DMI_ADDR_BITS-1:0] addr_q;
  logic [DMI_DATA_BITS-1:0] data_q;
  logic [DMI_OP_BITS-1:0]   op_q;

  logic [DMI_ADDR_BITS-1:0] in_addr;
  logic [DMI_DATA_BITS-1:0] in_data;
  logic [DMI_OP_BITS-1:0]   in_op;
  logic                     in_is_dm;

  assign in_op    = dtm_req_data_i[DMI_OP_BITS-1:0];
  assign in_data  = dtm_req_data_i[DMI_OP_BITS +: DMI_DATA_BITS];
  assign in_addr  = dtm_req_data_i[DMI_OP_BITS + DMI_DATA_BITS +: DMI_ADDR_BITS];
  assign in_is_dm = (in_op == OP_READ) || (in_op == OP_WRITE);

  assign dmi_req_addr_o = addr_q;
  assign dmi_req_data_o = data_q;
  assign dmi_req_op_o   = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      dtm_ack_o        <= 1'b0;
      dtm_resp_o       <= 1'b0;
      dtm_resp_data_o  <= '0;
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
      op_q             <= '0;
    end else begin
      // Ack follows the synchronized request low regardless of FSM state.
      if (!sync_req) dtm_ack_o <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (sync_req && !dtm_ack_o) begin
            dtm_ack_o <= 1'b1;
            addr_q    <= in_addr;
            data_q    <= in_data;
            op_q      <= in_op;
            if (in_is_dm) begin
              dmi_req_valid_o <= 1'b1;
              state_q         <= S_DM_REQ;
            end else begin
              // Nop and reserved ops are answered locally without a DM access.
              dtm_resp_data_o <= {in_addr, {DMI_DATA_BITS{1'b0}},
                                  (in_op == OP_NOP) ? RSP_OK : RSP_FAILED};
              dtm_resp_o      <= 1'b1;
              state_q         <= S_RESP_HI;
            end
          end
        end
        S_DM_REQ: begin
          if (dmi_req_ready_i) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
            state_q          <= S_DM_WAIT;
          end
        end
        S_DM_WAIT: begin
          if (dmi_resp_valid_i) begin
            dmi_resp_ready_o <= 1'b0;
            dtm_resp_data_o  <= {addr_q, dmi_resp_data_i, dmi_resp_op_i};
            dtm_resp_o       <= 1'b1;
            state_q          <= S_RESP_HI;
          end
        end
        S_RESP_HI: begin
          if (sync_ack) begin
            dtm_resp_o <= 1'b0;
            state_q    <= S_RESP_LO;
          end
        end
        S_RESP_LO: begin
          if (!sync_ack) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmi_dm_endpoint.md
DMI_DM_ENDPOINT -- requirements
Module: dmi_dm_endpoint

Interface
REQ-001 Parameters SHALL be DMI_ADDR_BITS (default 6, DMI address width), DMI_DATA_BITS (default 32, DMI data width) and DMI_OP_BITS (default 2, DMI op width); W = sum of the three (default 40).
REQ-002 Ports SHALL be:
- clk  in  1  DM core clock
- rst_n  in  1  reset; asynchronous, active-low
- dtm_req_i  in  1  4-phase request from the JTAG-clock-domain DTM
- dtm_req_data_i  in  W  request word {addr, data, op}, op in the LSBs
- dtm_ack_o  out  1  request acknowledge to the DTM
- dtm_resp_o  out  1  4-phase response request to the DTM
- dtm_resp_data_o  out  W  response word {addr, data, op}
- dtm_resp_ack_i  in  1  response acknowledge from the DTM
- dmi_req_valid_o  out  1  request valid toward the DM
- dmi_req_ready_i  in  1  DM accepts the request
- dmi_req_addr_o  out  DMI_ADDR_BITS  request address
- dmi_req_data_o  out  DMI_DATA_BITS  request write data
- dmi_req_op_o  out  DMI_OP_BITS  request op (1 = read, 2 = write)
- dmi_resp_valid_i  in  1  DM response valid
- dmi_resp_ready_o  out  1  endpoint accepts the DM response
- dmi_resp_data_i  in  DMI_DATA_BITS  response read data
- dmi_resp_op_i  in  DMI_OP_BITS  response status (0 = ok, 2 = failed)

Function
REQ-003 dtm_req_i and dtm_resp_ack_i SHALL each pass through a 2-flop synchronizer before any use; data inputs SHALL NOT be synchronized and SHALL be sampled only while the synchronized req is high.
REQ-004 The FSM SHALL have five states:
- IDLE
- DM_REQ: dmi_req_valid_o = 1
- DM_WAIT: dmi_resp_ready_o = 1
- RESP_HI: dtm_resp_o = 1
- RESP_LO: wait for the acknowledge to fall
REQ-005 In IDLE with sync_req = 1 and dtm_ack_o = 0, the block SHALL capture dtm_req_data_i into the request register and set dtm_ack_o = 1 on that edge.
REQ-006 On that same capture edge, the next state SHALL follow the captured op:
- op 1 or 2: DM_REQ
- op 0 (nop): RESP_HI with response data 0 and op 0
- op 3: RESP_HI with response data 0 and op 2
REQ-007 dtm_ack_o SHALL clear on the first edge on which sync_req = 0, independent of FSM state.
REQ-008 A new request SHALL NOT be captured outside IDLE; while the FSM is busy, it SHALL stall unacknowledged.
REQ-009 Latency: dmi_req_valid_o SHALL rise after the 3rd rising clk edge following the dtm_req_i rise (2 synchronizer edges plus 1 capture edge).
REQ-010 DM_REQ: the address, data and op outputs SHALL be held stable while valid is high; on the edge with dmi_req_ready_i = 1, the FSM SHALL go to DM_WAIT.
REQ-011 DM_WAIT: on the edge with dmi_resp_valid_i = 1, the block SHALL load dtm_resp_data_o = {captured addr, dmi_resp_data_i, dmi_resp_op_i} and go to RESP_HI.
REQ-012 A response that is valid in the same cycle as the request handshake SHALL NOT be consumed; dmi_resp_ready_o SHALL be asserted only in DM_WAIT.
REQ-013 RESP_HI: dtm_resp_o SHALL be 1 with data already stable; on sync_ack = 1, the block SHALL clear dtm_resp_o and go to RESP_LO.
REQ-014 RESP_LO: on sync_ack = 0, the FSM SHALL go to IDLE; dtm_resp_data_o SHALL stay unchanged until the next response load.
REQ-015 The block SHALL deliver exactly one response per captured request, including nop and reserved ops.

Reset
REQ-016 The following SHALL be reset: FSM to IDLE; synchronizers, dtm_ack_o, dtm_resp_o, dmi_req_valid_o and dmi_resp_ready_o to 0; all data registers to 0.
REQ-017 A reset asserted mid-transaction SHALL abandon that transaction without emitting a response; after release, the block SHALL accept the next request normally.

Structure
REQ-018 Package dmi_pkg SHALL hold:
- the DMI width constants
- the op encodings (NOP 0, READ 1, WRITE 2, RSVD 3)
- the status encodings (OK 0, FAILED 2, BUSY 3)
- the packed request/response struct
- the FSM state enum
REQ-019 The synchronizer SHALL be a sub-module cdc_sync_2ff (1-bit, asynchronous reset to 0), instantiated twice.

Verification
REQ-020 Read: request {addr 0x11, data 0, op 1}; DM returns data 0xDEADBEEF, op 0 -> dmi_req_addr_o = 0x11 and op = 1; response word = {0x11, 0xDEADBEEF, 0}; 4-phase cycle completes; FSM back in IDLE.
REQ-021 Write: request {addr 0x04, data 0x00000001, op 2}, with dmi_req_ready_i held low for 5 cycles -> valid and data held stable for all 5 cycles; exactly one handshake.
REQ-022 Nop: request op 0 -> no dmi_req_valid_o pulse; response = {addr, 0, 0}.
REQ-023 Reserved op: request op 3 -> no DM access; response op = 2.
REQ-024 Back-to-back: second dtm_req_i raised while the FSM is in RESP_LO -> second request not acknowledged before IDLE; both responses delivered in order.
REQ-025 Reset: rst_n pulsed while in DM_WAIT -> all outputs 0 immediately; a subsequent read completes correctly.
